// File: rtl/miriscv_data_mem_resp.sv
// Data-memory responder for the core's req/gnt/rvalid data port, backed by a word array.
// Latency: accept at edge k -> single-cycle rvalid between edges k+WAIT_CYCLES and k+WAIT_CYCLES+1.
// Backpressure: gnt is high only in IDLE, so there is at most one outstanding request.
// Ports: clk_i/arstn_i clock and async active-low reset; data_req_i/we/be/addr/wdata request
//        from the core; data_gnt_o accept; data_rvalid_o/rdata_o/err_o response.
module miriscv_data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  // Byte-address width of the array and word-index width.
  localparam int unsigned AW = $clog2(4 * DEPTH_WORDS);
  localparam int unsigned IW = AW - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [3:0]    cnt;

  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  logic          err_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          commit;

  // Access attributes seen on the commit edge.
  logic          c_we;
  logic [3:0]    c_be;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [31:0]   c_off;
  logic          c_err;
  logic [IW-1:0] c_idx;

  assign accept = data_req_i && (state == S_IDLE);

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = S_RESP;
          commit    = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the access
  // must come straight from the inputs rather than from the (not yet loaded) latches.
  assign c_we    = (state == S_IDLE) ? data_we_i    : we_q;
  assign c_be    = (state == S_IDLE) ? data_be_i    : be_q;
  assign c_addr  = (state == S_IDLE) ? data_addr_i  : addr_q;
  assign c_wdata = (state == S_IDLE) ? data_wdata_i : wdata_q;

  // Addresses below BASE_ADDR wrap to a large offset and fail the range test.
  // BASE_ADDR is aligned to the array size, so c_off[1:0] equals addr[1:0].
  assign c_off = c_addr - BASE_ADDR;
  assign c_err = (c_off[1:0] != 2'b00) || (c_off[31:AW] != '0);
  assign c_idx = c_off[AW-1:2];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= 4'(WAIT_CYCLES);
        we_q    <= data_we_i;
        be_q    <= data_be_i;
        addr_q  <= data_addr_i;
        wdata_q <= data_wdata_i;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_q <= c_err;
        // Loads return the full word regardless of be; stores leave rdata untouched.
        if (c_err) begin
          rdata_q <= 32'd0;
        end else if (!c_we) begin
          rdata_q <= mem[c_idx];
        end
      end
    end
  end

  // Array is not reset. A reset before the commit edge leaves state != WAIT,
  // so a dropped store can never reach this write.
  always_ff @(posedge clk_i) begin
    if (commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) begin
          mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

  assign data_gnt_o    = (state == S_IDLE);
  assign data_rvalid_o = (state == S_RESP);
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_miriscv_data_mem_resp.sv
// Bench for miriscv_data_mem_resp: scoreboard of expected responses on the WAIT_CYCLES=2
// instance, plus throughput checks on WAIT_CYCLES=0 and WAIT_CYCLES=3 instances.
// Inputs are driven after the falling edge; outputs are sampled on the falling edge.
module tb_miriscv_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req2 = 1'b0, req0 = 1'b0, req3 = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic        gnt2, rv2, err2;
  logic [31:0] rdata2;
  logic        gnt0, rv0, err0;
  logic [31:0] rdata0;
  logic        gnt3, rv3, err3;
  logic [31:0] rdata3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    bit          chk_data;
    int          exp_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  miriscv_data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut2 (
    .clk_i(clk), .arstn_i(rst_n), .data_req_i(req2), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt2), .data_rvalid_o(rv2),
    .data_rdata_o(rdata2), .data_err_o(err2));

  miriscv_data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk_i(clk), .arstn_i(rst_n), .data_req_i(req0), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt0), .data_rvalid_o(rv0),
    .data_rdata_o(rdata0), .data_err_o(err0));

  miriscv_data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) dut3 (
    .clk_i(clk), .arstn_i(rst_n), .data_req_i(req3), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt3), .data_rvalid_o(rv3),
    .data_rdata_o(rdata3), .data_err_o(err3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid on the scoreboarded instance pops one expectation.
  always @(negedge clk) begin
    if (rst_n && rv2) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got rvalid at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_cycle"}, cyc, e.exp_cyc);
        check({e.name, "_err"}, {31'd0, err2}, {31'd0, e.err});
        if (e.chk_data) check({e.name, "_rdata"}, rdata2, e.rdata);
        check({e.name, "_gnt_in_resp"}, {31'd0, gnt2}, 32'd0);
      end
    end
  end

  // Issue one request to dut2 and queue its expected response (rvalid 2 edges after accept).
  task automatic issue(input string name, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit exp_err, input logic [31:0] exp_rdata, input bit chk_data);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!gnt2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    req2 = 1'b1; we = w; be = b; addr = a; wdata = d;
    e.err = exp_err; e.rdata = exp_rdata; e.chk_data = chk_data;
    e.exp_cyc = cyc + 1 + 2; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1 req2 = 1'b0;
    // Input changes while busy must be ignored.
    addr = 32'hFFFF_FFF0; wdata = 32'h5A5A_5A5A; we = ~w; be = ~b;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending responses expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic xfer(input string name, input bit w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit exp_err, input logic [31:0] exp_rdata, input bit chk_data);
    issue(name, w, b, a, d, exp_err, exp_rdata, chk_data);
    drain(name);
  endtask

  // Hold req high for 20 edges on a throughput instance; count accepts and rvalid pulses.
  task automatic stream(input string name, input int wc, input int exp_acc);
    int acc = 0, rv = 0, overlap = 0;
    logic g, r;
    @(negedge clk);
    we = 1'b0; be = 4'hF; addr = 32'h10;
    if (wc == 0) req0 = 1'b1; else req3 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      g = (wc == 0) ? gnt0 : gnt3;
      r = (wc == 0) ? rv0 : rv3;
      if (g && r) overlap++;
      if (r) rv++;
      @(posedge clk);
      if (g) acc++;
      @(negedge clk);
    end
    req0 = 1'b0; req3 = 1'b0;
    for (int i = 0; i < wc + 2; i++) begin
      r = (wc == 0) ? rv0 : rv3;
      g = (wc == 0) ? gnt0 : gnt3;
      if (g && r) overlap++;
      if (r) rv++;
      @(negedge clk);
    end
    check({name, "_accepts"}, acc, exp_acc);
    check({name, "_rvalids"}, rv, exp_acc);
    check({name, "_gnt_while_busy"}, overlap, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_gnt", {31'd0, gnt2}, 32'd1);
    check("reset_rvalid", {31'd0, rv2}, 32'd0);
    check("reset_err", {31'd0, err2}, 32'd0);
    check("reset_rdata", rdata2, 32'd0);
    rst_n = 1'b1;

    // Write then read.
    xfer("st_deadbeef", 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    xfer("ld_deadbeef", 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);

    // Byte enables; load ignores be.
    xfer("st_pre20", 1'b1, 4'hF, 32'h20, 32'h1122_3344, 1'b0, 32'h0, 1'b0);
    xfer("st_be5", 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 1'b0, 32'h0, 1'b0);
    xfer("ld_be5", 1'b0, 4'b0000, 32'h20, 32'h0, 1'b0, 32'h11BB_33DD, 1'b1);
    xfer("st_be0", 1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    xfer("ld_be0", 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'h11BB_33DD, 1'b1);
    xfer("st_be8", 1'b1, 4'b1000, 32'h24, 32'h7700_0000, 1'b0, 32'h0, 1'b0);
    xfer("ld_be8", 1'b0, 4'hF, 32'h24, 32'h0, 1'b0, 32'h7700_0000, 1'b0);

    // Errors: misaligned load, out-of-range store must not alias onto word 0.
    xfer("st_pre0", 1'b1, 4'hF, 32'h0, 32'hCAFE_0001, 1'b0, 32'h0, 1'b0);
    xfer("st_pre_top", 1'b1, 4'hF, 32'hFFC, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0);
    xfer("ld_mis13", 1'b0, 4'hF, 32'h13, 32'h0, 1'b1, 32'h0, 1'b1);
    xfer("st_oor1000", 1'b1, 4'hF, 32'h1000, 32'h9999_9999, 1'b1, 32'h0, 1'b0);
    xfer("ld_w0_after", 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'hCAFE_0001, 1'b1);
    xfer("ld_top_ok", 1'b0, 4'hF, 32'hFFC, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b1);
    xfer("ld_oor_rd", 1'b0, 4'hF, 32'h1004, 32'h0, 1'b1, 32'h0, 1'b1);
    xfer("ld_dead_again", 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);

    // Continuous request throughput.
    stream("w0", 0, 10);
    stream("w3", 3, 4);

    // Reset during WAIT drops the store.
    xfer("st_pre40", 1'b1, 4'hF, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0);
    issue("st_40_dropped", 1'b1, 4'hF, 32'h40, 32'h0000_00FF, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_gnt", {31'd0, gnt2}, 32'd1);
    check("rst_mid_rvalid", {31'd0, rv2}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    xfer("ld_40_after_rst", 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, 32'h0, 1'b1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/miriscv_data_mem_resp.md
# miriscv_data_mem_resp

Data-memory responder for `miriscv_core`'s load/store unit. It is the slave end of the core's request/grant/response data interface. The block accepts one request at a time and holds it for a fixed, parameterised number of wait states. It then commits the write or returns the read with a single-cycle `rvalid` pulse. It replaces the ideal zero-wait memory in the processor bench so the core's stall logic is exercised under realistic latency.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; legal range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `4*DEPTH_WORDS`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `arstn_i`  in  1  asynchronous, active-low reset.
- `data_req_i`  in  1  request valid from the core.
- `data_we_i`  in  1  1 = store, 0 = load.
- `data_be_i`  in  4  byte enables for stores; bit n covers bits [8n+7:8n].
- `data_addr_i`  in  32  byte address.
- `data_wdata_i`  in  32  store data.
- `data_gnt_o`  out  1  responder ready; a request is accepted on any edge where `data_req_i && data_gnt_o`.
- `data_rvalid_o`  out  1  one-cycle response strobe.
- `data_rdata_o`  out  32  load data; valid only while `data_rvalid_o`.
- `data_err_o`  out  1  access error; valid only while `data_rvalid_o`.

## Operation
- FSM has three states: IDLE, WAIT and RESP.
  - `data_gnt_o` = (state == IDLE), a pure decode of state.
- **IDLE, on accept:**
  - Latch `we`, `be`, `addr` and `wdata`.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or directly to RESP if `WAIT_CYCLES` == 0.
- **WAIT:** decrement the counter each edge. When the counter is 1, the next state is RESP.
- **RESP:**
  - `data_rvalid_o` = 1 for exactly this one cycle.
  - Next state is IDLE, unconditionally.
- **Commit:** the memory access happens on the edge that enters RESP.
  - Store: only lanes with `be` set are written. `be` = 4'b0000 is a legal no-op that still responds.
  - Load: `data_rdata_o` is registered on the same edge and holds the full word, regardless of `be`.
- **Error:** raised when the latched address is misaligned (`addr[1:0]` != 0) or outside [`BASE_ADDR`, `BASE_ADDR`+4*`DEPTH_WORDS`).
  - `data_err_o` = 1 with `rvalid`.
  - No write occurs.
  - `data_rdata_o` = 0.
- **Word index** = (`addr` − `BASE_ADDR`)[log2(4*`DEPTH_WORDS`)−1:2].
- **Input sampling:** inputs are sampled only on the accept edge. Changes while not granted are ignored.
- **Outstanding requests:** at most one. `data_req_i` held high through WAIT/RESP is not a second request until `gnt` returns.

## Timing
- **Reset values:** state = IDLE, so `data_gnt_o` = 1. `data_rvalid_o` = 0, `data_err_o` = 0, `data_rdata_o` = 0, wait counter = 0. The memory array is not reset; its contents are undefined.
- **Accept at edge k:**
  - `gnt` falls after edge k.
  - `rvalid` is high between edges k+`WAIT_CYCLES` and k+`WAIT_CYCLES`+1.
  - `gnt` rises after edge k+`WAIT_CYCLES`+1.
- **Back-to-back:** the earliest next accept is edge k+`WAIT_CYCLES`+2. Peak throughput is one transaction per `WAIT_CYCLES`+2 cycles.
- **Zero-wait case:** with `WAIT_CYCLES` = 0, `rvalid` is high in the cycle right after the accept edge.
- **Hazards:** read-after-write to the same word returns the new data, because the accesses are serialized by the FSM.
- **`data_rdata_o` outside RESP:** holds its last registered value; consumers must qualify it with `rvalid`.
- **Reset asserted mid-transaction:** everything clears immediately (asynchronously). The pending transaction is dropped.
  - If reset is asserted before the commit edge, no write occurs.
  - No `rvalid` is produced after reset deasserts.
- **Reset deassertion:** `arstn_i` is released synchronously by the surrounding logic. The first accept is legal on the first edge after release.

## Test plan
- **Write then read, `WAIT_CYCLES`=2:**
  - Store 32'hDEAD_BEEF to 0x10 with `be` = 4'hF, accepted at edge k → `rvalid` high only between edges k+2 and k+3, `err` = 0.
  - Load from 0x10 → `rdata` = 32'hDEAD_BEEF.
- **Byte enables:**
  - Preload 32'h1122_3344 at 0x20.
  - Store 32'hAABB_CCDD with `be` = 4'b0101, then load → 32'h11BB_33DD.
  - Store with `be` = 4'b0000 → `rvalid` still pulses and the word is unchanged.
- **Errors:**
  - Load 0x13 → `rvalid` = 1, `err` = 1, `rdata` = 0.
  - Store to 4*`DEPTH_WORDS` (0x1000 at default depth) → `err` = 1, and no word in the array changes.
- **Handshake under continuous request:**
  - Hold `req` high for 20 cycles with `WAIT_CYCLES` = 0 → accepts on every 2nd edge and 10 `rvalid` pulses.
  - Repeat with `WAIT_CYCLES` = 3 → one accept per 5 cycles.
  - `gnt` never high during WAIT or RESP.
- **Reset mid-operation:**
  - Accept a store of 32'h0000_00FF to 0x40 over a prior value of 32'h0, then pulse `arstn_i` low during WAIT → no `rvalid`, `gnt` = 1 immediately.
  - Subsequent load of 0x40 → 32'h0.
- **Core integration:** run the processor bench with `WAIT_CYCLES` = 3 → the core stalls on every load/store, and `result` matches the zero-wait run.
